// File: rtl/lcd_cmd_arb.sv
// lcd_cmd_arb: command arbiter and sequencer in front of the LCD image
// controller. Two requesters queue 3-bit commands into private FIFOs.
// The FIFOs are granted round-robin, and one command at a time is issued
// to the controller while its busy flag is honoured. Command 0 (write) is
// terminal. After it is issued, both queues are flushed, the block waits
// for lcd_done and then raises all_done.
//
// Ports:
//   clk, reset               single clock, synchronous active-high reset
//   req0_valid/cmd/ready     requester 0 push interface
//   req1_valid/cmd/ready     requester 1 push interface
//   lcd_busy, lcd_done       controller status
//   cmd, cmd_valid           registered command and one-cycle issue strobe
//   grant_id                 requester that supplied the current cmd
//   issued_cnt               commands issued since reset, saturates at 255
//   all_done                 sticky completion flag
module lcd_cmd_arb #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [2:0] req0_cmd,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_cmd,
    output logic       req1_ready,
    input  logic       lcd_busy,
    input  logic       lcd_done,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic       grant_id,
    output logic [7:0] issued_cnt,
    output logic       all_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [2:0] {BOOT, ARB, ISSUE, GAP, DRAIN, FINISH} state_t;

    state_t state;
    logic   rr;

    // Index 0/1 selects the requester.
    logic [2:0]    mem [2][FIFO_DEPTH];
    logic [AW-1:0] wr_ptr [2];
    logic [AW-1:0] rd_ptr [2];
    logic [AW:0]   count [2];

    logic [1:0] req_valid;
    logic [2:0] req_cmd [2];
    logic [1:0] req_ready;
    logic [1:0] empty;
    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;
    logic       accepting;
    logic       grant_sel;
    logic       pop_en;
    logic       flush;
    logic [2:0] head;

    assign req_valid  = {req1_valid, req0_valid};
    assign req_cmd[0] = req0_cmd;
    assign req_cmd[1] = req1_cmd;
    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    // NOTE: every signal written in always_comb gets a value at the top of
    // the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        accepting = (state == BOOT) || (state == ARB) ||
                    (state == ISSUE) || (state == GAP);
        empty     = '0;
        full      = '0;
        req_ready = '0;
        push      = '0;
        pop       = '0;
        for (int i = 0; i < 2; i++) begin
            empty[i]     = (count[i] == '0);
            full[i]      = (count[i] == CNT_FULL);
            req_ready[i] = !full[i] && accepting;
            push[i]      = req_valid[i] && req_ready[i];
        end
        // When both FIFOs hold data, rr decides. Otherwise the one with
        // data wins. If FIFO 0 is empty, FIFO 1 is the only candidate.
        grant_sel = (!empty[0] && !empty[1]) ? rr : empty[0];
        pop_en    = (state == ARB) && !lcd_busy && (empty != 2'b11);
        pop[0]    = pop_en && !grant_sel;
        pop[1]    = pop_en && grant_sel;
        head      = mem[grant_sel][rd_ptr[grant_sel]];
        // cmd still holds the command issued last cycle while in ISSUE.
        flush     = (state == ISSUE) && (cmd == 3'd0);
    end

    // NOTE: the storage array has no reset. Validity comes from count
    // alone, so clearing the data words would only add reset fan-out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= req_cmd[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff reads the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || flush) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end else begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
                if (push[i] && !pop[i])
                    count[i] <= count[i] + CNT_ONE;
                else if (pop[i] && !push[i])
                    count[i] <= count[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BOOT;
            rr         <= 1'b0;
            cmd        <= 3'd0;
            cmd_valid  <= 1'b0;
            grant_id   <= 1'b0;
            issued_cnt <= 8'd0;
            all_done   <= 1'b0;
        end else begin
            case (state)
                // Wait for the controller to finish its image load.
                BOOT: if (!lcd_busy) state <= ARB;
                ARB: begin
                    if (pop_en) begin
                        cmd       <= head;
                        grant_id  <= grant_sel;
                        cmd_valid <= 1'b1;
                        rr        <= !grant_sel;
                        if (issued_cnt != 8'hFF) issued_cnt <= issued_cnt + 8'd1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cmd_valid <= 1'b0;
                    state     <= (cmd == 3'd0) ? DRAIN : GAP;
                end
                // One idle cycle so the controller's busy response is visible.
                GAP: state <= ARB;
                DRAIN: begin
                    if (lcd_done) begin
                        all_done <= 1'b1;
                        state    <= FINISH;
                    end
                end
                FINISH: all_done <= 1'b1;
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_arb.sv
module tb_lcd_cmd_arb;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [2:0] req0_cmd, req1_cmd;
    logic       req0_ready, req1_ready;
    logic       lcd_busy, lcd_done;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       grant_id;
    logic [7:0] issued_cnt;
    logic       all_done;

    lcd_cmd_arb #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
        .lcd_busy(lcd_busy), .lcd_done(lcd_done),
        .cmd(cmd), .cmd_valid(cmd_valid), .grant_id(grant_id),
        .issued_cnt(issued_cnt), .all_done(all_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef enum {M_BOOT, M_ARB, M_ISSUE, M_GAP, M_DRAIN, M_FIN} mphase_t;
    mphase_t    mph = M_BOOT;
    logic [2:0] mq0[$];
    logic [2:0] mq1[$];
    logic [2:0] m_cmd = 0;
    bit         m_cv = 0, m_gid = 0, m_done = 0, m_rr = 0, m_live = 0;
    int         m_cnt = 0;

    function automatic bit m_accepting();
        return mph inside {M_BOOT, M_ARB, M_ISSUE, M_GAP};
    endfunction

    always @(posedge clk) begin
        bit p0, p1, flush_now;
        int g;
        p0 = req0_valid && m_accepting() && (mq0.size() < DEPTH);
        p1 = req1_valid && m_accepting() && (mq1.size() < DEPTH);
        flush_now = (mph == M_ISSUE) && (m_cmd == 0);
        if (reset) begin
            mq0.delete(); mq1.delete();
            mph = M_BOOT; m_cmd = 0; m_cv = 0; m_gid = 0; m_cnt = 0;
            m_done = 0; m_rr = 0; m_live = 1;
        end else begin
            case (mph)
                M_BOOT: if (!lcd_busy) mph = M_ARB;
                M_ARB: if (!lcd_busy && (mq0.size() > 0 || mq1.size() > 0)) begin
                    if (mq0.size() > 0 && mq1.size() > 0) g = m_rr;
                    else g = (mq0.size() > 0) ? 0 : 1;
                    m_cmd = (g == 1) ? mq1.pop_front() : mq0.pop_front();
                    m_gid = g[0];
                    m_cv  = 1;
                    if (m_cnt < 255) m_cnt++;
                    m_rr  = (g == 0);
                    mph   = M_ISSUE;
                end
                M_ISSUE: begin
                    m_cv = 0;
                    mph  = (m_cmd == 0) ? M_DRAIN : M_GAP;
                end
                M_GAP: mph = M_ARB;
                M_DRAIN: if (lcd_done) begin m_done = 1; mph = M_FIN; end
                default: ;
            endcase
            if (p0) mq0.push_back(req0_cmd);
            if (p1) mq1.push_back(req1_cmd);
            if (flush_now) begin mq0.delete(); mq1.delete(); end
        end
    end

    // Issue log taken from the DUT for the directed scenario checks.
    typedef struct { logic [2:0] c; logic g; int t; } ent_t;
    ent_t log_q[$];

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            check("cmd",        cmd,        m_cmd);
            check("cmd_valid",  cmd_valid,  m_cv);
            check("grant_id",   grant_id,   m_gid);
            check("issued_cnt", issued_cnt, m_cnt);
            check("all_done",   all_done,   m_done);
            check("req0_ready", req0_ready, m_accepting() && mq0.size() < DEPTH);
            check("req1_ready", req1_ready, m_accepting() && mq1.size() < DEPTH);
            if (cmd_valid === 1'b1) log_q.push_back('{c: cmd, g: grant_id, t: cyc});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic busy);
        reset = 1; req0_valid = 0; req1_valid = 0; req0_cmd = 0; req1_cmd = 0;
        lcd_done = 0; lcd_busy = busy;
        tick(); tick();
        reset = 0;
        log_q.delete();
    endtask

    task automatic push_both(input logic v0, input logic [2:0] c0,
                             input logic v1, input logic [2:0] c1);
        req0_valid = v0; req0_cmd = c0; req1_valid = v1; req1_cmd = c1;
        tick();
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic wait_issue(input int budget, input string name);
        int n = 0;
        while (cmd_valid !== 1'b1 && n < budget) begin tick(); n++; end
        check({name, "_timeout"}, (n < budget), 1);
    endtask

    initial begin
        int acc, last_hi, iss_t;
        reset = 1; req0_valid = 0; req1_valid = 0; req0_cmd = 0; req1_cmd = 0;
        lcd_busy = 0; lcd_done = 0;

        // Boot hold.
        do_reset(1);
        check("boot_ready0", req0_ready, 1);
        push_both(1, 3, 0, 0);
        push_both(1, 4, 0, 0);
        repeat (68) tick();
        check("boot_no_issue", log_q.size(), 0);
        lcd_busy = 0;
        repeat (15) tick();
        check("boot_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("boot_c0", log_q[0].c, 3);
            check("boot_c1", log_q[1].c, 4);
            check("boot_g",  {log_q[0].g, log_q[1].g}, 0);
            check("boot_gap", log_q[1].t - log_q[0].t, 3);
        end

        // Round-robin.
        do_reset(1);
        push_both(1, 1, 1, 2);
        push_both(1, 1, 1, 2);
        lcd_busy = 0;
        repeat (20) tick();
        check("rr_n", log_q.size(), 4);
        if (log_q.size() == 4)
            check("rr_order", {log_q[0].c, 1'(log_q[0].g), log_q[1].c, 1'(log_q[1].g),
                               log_q[2].c, 1'(log_q[2].g), log_q[3].c, 1'(log_q[3].g)},
                  {3'd1, 1'b0, 3'd2, 1'b1, 3'd1, 1'b0, 3'd2, 1'b1});
        check("rr_cnt", issued_cnt, 4);
        check("rr_model_cnt", m_cnt, 4);

        // Full FIFO.
        do_reset(1);
        acc = 0;
        req1_valid = 1; req1_cmd = 5;
        for (int i = 0; i < 6; i++) begin
            if (req1_ready) acc++;
            tick();
        end
        req1_valid = 0;
        check("full_accepts", acc, 4);
        check("full_ready_low", req1_ready, 0);
        lcd_busy = 0;
        repeat (30) tick();
        check("full_issues", log_q.size(), 4);

        // Terminal write.
        do_reset(1);
        push_both(1, 5, 1, 7);
        push_both(1, 0, 0, 0);
        push_both(1, 6, 0, 0);
        lcd_busy = 0;
        repeat (20) tick();
        check("term_n", log_q.size(), 3);
        if (log_q.size() == 3)
            check("term_order", {log_q[0].c, 1'(log_q[0].g), log_q[1].c, 1'(log_q[1].g),
                                 log_q[2].c, 1'(log_q[2].g)},
                  {3'd5, 1'b0, 3'd7, 1'b1, 3'd0, 1'b0});
        check("term_ready", {req0_ready, req1_ready}, 0);
        check("term_done_pre", all_done, 0);
        push_both(1, 2, 1, 2);
        lcd_done = 1;
        tick();
        lcd_done = 0;
        check("term_done", all_done, 1);
        repeat (5) tick();
        check("term_done_sticky", all_done, 1);
        check("term_cnt", issued_cnt, 3);
        check("term_ready_fin", {req0_ready, req1_ready}, 0);

        // Busy stall during GAP.
        do_reset(1);
        push_both(1, 1, 0, 0);
        push_both(1, 2, 0, 0);
        lcd_busy = 0;
        wait_issue(20, "stall_first");
        tick();
        lcd_busy = 1;
        repeat (3) tick();
        lcd_busy = 0;
        last_hi = cyc - 1;
        repeat (10) tick();
        check("stall_n", log_q.size(), 2);
        iss_t = (log_q.size() == 2) ? log_q[1].t : -100;
        check("stall_delay", iss_t - last_hi, 2);

        // Mid-drain reset.
        do_reset(0);
        push_both(1, 0, 0, 0);
        repeat (8) tick();
        check("drain_ready", {req0_ready, req1_ready}, 0);
        reset = 1;
        tick();
        check("rst_outs", {cmd, cmd_valid, grant_id, issued_cnt, all_done}, 0);
        check("rst_ready", {req0_ready, req1_ready}, 2'b11);
        reset = 0;
        log_q.delete();
        push_both(1, 4, 0, 0);
        repeat (10) tick();
        check("rst_fresh_n", log_q.size(), 1);
        if (log_q.size() == 1) check("rst_fresh", {log_q[0].c, 1'(log_q[0].g)}, {3'd4, 1'b0});

        // Saturation of issued_cnt.
        do_reset(0);
        for (int i = 0; i < 900; i++) begin
            req0_valid = 1; req0_cmd = 3'($urandom_range(1, 7));
            req1_valid = $urandom % 2; req1_cmd = 3'($urandom_range(1, 7));
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        check("sat_cnt", issued_cnt, 255);

        // Random traffic, compared cycle by cycle against the model.
        do_reset(0);
        for (int i = 0; i < 2000; i++) begin
            req0_valid = $urandom % 2;
            req0_cmd   = ($urandom % 12 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            req1_valid = $urandom % 2;
            req1_cmd   = ($urandom % 12 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            lcd_busy   = ($urandom % 4 == 0);
            lcd_done   = ($urandom % 6 == 0);
            reset      = ($urandom % 250 == 0) || (all_done && ($urandom % 4 == 0));
            tick();
        end
        reset = 0; req0_valid = 0; req1_valid = 0; lcd_busy = 0; lcd_done = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
